// File: rtl/mlp_pkg.sv
// Shared types and constants for the two-layer MLP sequencer.
package mlp_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_L1_A,
        S_L1_W,
        S_L1_MAC,
        S_L2_W,
        S_L2_MAC,
        S_DONE
    } mlp_seq_state_t;

    // r_sh_en bit positions
    localparam int SH_A  = 0;
    localparam int SH_W1 = 1;
    localparam int SH_W2 = 2;

    // mac_en / mac_clr lanes
    localparam int MAC_L1 = 0;
    localparam int MAC_L2 = 1;

endpackage

// File: rtl/mlp_addr_gen.sv
// Offset counters and address adders for the MLP sequencer; weight offsets are
// kept as running sums so no multiplier is needed.
module mlp_addr_gen #(
    parameter int ADDR_WIDTH    = 16,
    parameter int ADDR_BASE_A   = 0,
    parameter int ADDR_BASE_W   = 0,
    parameter int ADDR_BASE_REG = 0,
    parameter int N_IN          = 400,
    parameter int N_HID         = 25,
    parameter int N_OUT         = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_all,
    input  logic                  i_inc,
    input  logic                  k_inc,
    input  logic                  k_clr,
    input  logic                  j_inc,
    output logic                  i_last,
    output logic                  k_last_l1,
    output logic                  k_last_l2,
    output logic                  j_last,
    output logic [ADDR_WIDTH-1:0] a_addr,
    output logic [ADDR_WIDTH-1:0] w1_addr,
    output logic [ADDR_WIDTH-1:0] w2_addr,
    output logic [ADDR_WIDTH-1:0] reg_addr
);

    localparam int KMAX = (N_HID > N_OUT) ? N_HID : N_OUT;
    localparam int IW   = $clog2(N_IN + 2);
    localparam int JW   = $clog2(N_HID + 2);
    localparam int KW   = $clog2(KMAX + 2);
    localparam logic [ADDR_WIDTH-1:0] L2_BASE = ADDR_WIDTH'(ADDR_BASE_W + (N_IN + 1) * N_HID);

    logic [IW-1:0]         i;
    logic [JW-1:0]         j;
    logic [KW-1:0]         k;
    logic [ADDR_WIDTH-1:0] w1_off;
    logic [ADDR_WIDTH-1:0] w2_off;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i      <= '0;
            j      <= '0;
            k      <= '0;
            w1_off <= '0;
            w2_off <= '0;
        end else if (clr_all) begin
            i      <= '0;
            j      <= '0;
            k      <= '0;
            w1_off <= '0;
            w2_off <= '0;
        end else begin
            if (i_inc) begin
                i      <= i + IW'(1);
                w1_off <= w1_off + ADDR_WIDTH'(N_HID);
            end
            if (k_clr)
                k <= '0;
            else if (k_inc)
                k <= k + KW'(1);
            if (j_inc) begin
                j      <= j + JW'(1);
                w2_off <= w2_off + ADDR_WIDTH'(N_OUT);
            end
        end
    end

    assign i_last    = (i == IW'(N_IN));
    assign k_last_l1 = (k == KW'(N_HID - 1));
    assign k_last_l2 = (k == KW'(N_OUT - 1));
    assign j_last    = (j == JW'(N_HID));

    assign a_addr   = ADDR_WIDTH'(ADDR_BASE_A) + ADDR_WIDTH'(i);
    assign w1_addr  = ADDR_WIDTH'(ADDR_BASE_W) + w1_off + ADDR_WIDTH'(k);
    assign w2_addr  = L2_BASE + w2_off + ADDR_WIDTH'(k);
    assign reg_addr = ADDR_WIDTH'(ADDR_BASE_REG) + ADDR_WIDTH'(j);

endmodule

// File: rtl/mlp_seq_ctrl.sv
// Two-layer MLP inference sequencer: fetch/shift/MAC control with a
// variable-latency read handshake. Define MLP_SEQ_ZERO_SKIP_EN for zero-activation skipping.
module mlp_seq_ctrl
    import mlp_pkg::*;
#(
    parameter int ADDR_WIDTH    = 16,
    parameter int ADDR_BASE_A   = 0,
    parameter int ADDR_BASE_W   = 0,
    parameter int ADDR_BASE_REG = 0,
    parameter int N_IN          = 400,
    parameter int N_HID         = 25,
    parameter int N_OUT         = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  clear,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic                  mem_rvalid,
    input  logic                  arg_zero,
    output logic [2:0]            r_sh_en,
    output logic [1:0]            mac_en,
    output logic [1:0]            mac_clr
);

    mlp_seq_state_t state, nxt;

    logic clr_all, i_inc, k_inc, k_clr, j_inc;
    logic i_last, k_last_l1, k_last_l2, j_last;
    logic skip;
    logic [ADDR_WIDTH-1:0] a_addr, w1_addr, w2_addr, reg_addr;

`ifdef MLP_SEQ_ZERO_SKIP_EN
    assign skip = mem_rvalid && arg_zero;
`else
    logic unused_arg_zero;
    assign unused_arg_zero = arg_zero;
    assign skip = 1'b0;
`endif

    mlp_addr_gen #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .ADDR_BASE_A  (ADDR_BASE_A),
        .ADDR_BASE_W  (ADDR_BASE_W),
        .ADDR_BASE_REG(ADDR_BASE_REG),
        .N_IN         (N_IN),
        .N_HID        (N_HID),
        .N_OUT        (N_OUT)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .clr_all  (clr_all),
        .i_inc    (i_inc),
        .k_inc    (k_inc),
        .k_clr    (k_clr),
        .j_inc    (j_inc),
        .i_last   (i_last),
        .k_last_l1(k_last_l1),
        .k_last_l2(k_last_l2),
        .j_last   (j_last),
        .a_addr   (a_addr),
        .w1_addr  (w1_addr),
        .w2_addr  (w2_addr),
        .reg_addr (reg_addr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt      = state;
        mem_rd   = 1'b0;
        mem_addr = '0;
        r_sh_en  = '0;
        mac_en   = '0;
        mac_clr  = '0;
        clr_all  = 1'b0;
        i_inc    = 1'b0;
        k_inc    = 1'b0;
        k_clr    = 1'b0;
        j_inc    = 1'b0;
        case (state)
            S_IDLE: begin
                mac_clr = 2'b11;
                if (start) begin
                    clr_all = 1'b1;
                    nxt     = S_L1_A;
                end
            end
            S_L1_A: begin
                mem_rd   = 1'b1;
                mem_addr = a_addr;
                if (mem_rvalid) begin
                    r_sh_en[SH_A] = 1'b1;
                    k_clr         = 1'b1;
                    // A zero activation still loads, but contributes nothing to the sum
                    if (skip) begin
                        i_inc = 1'b1;
                        nxt   = i_last ? S_L2_W : S_L1_A;
                    end else begin
                        nxt = S_L1_W;
                    end
                end
            end
            S_L1_W: begin
                mem_rd   = 1'b1;
                mem_addr = w1_addr;
                if (mem_rvalid) begin
                    r_sh_en[SH_W1] = 1'b1;
                    k_inc          = 1'b1;
                    if (k_last_l1)
                        nxt = S_L1_MAC;
                end
            end
            S_L1_MAC: begin
                mac_en[MAC_L1] = 1'b1;
                i_inc          = 1'b1;
                k_clr          = 1'b1;
                nxt            = i_last ? S_L2_W : S_L1_A;
            end
            S_L2_W: begin
                mem_rd   = 1'b1;
                mem_addr = w2_addr;
                if (mem_rvalid) begin
                    r_sh_en[SH_W2] = 1'b1;
                    k_inc          = 1'b1;
                    if (k_last_l2)
                        nxt = S_L2_MAC;
                end
            end
            S_L2_MAC: begin
                mac_en[MAC_L2] = 1'b1;
                mem_addr       = reg_addr;
                j_inc          = 1'b1;
                k_clr          = 1'b1;
                nxt            = j_last ? S_DONE : S_L2_W;
            end
            S_DONE: begin
                if (clear)
                    nxt = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
        // Abort cancels the pending read and drops any same-cycle beat
        if (abort && state != S_IDLE) begin
            nxt     = S_IDLE;
            mem_rd  = 1'b0;
            r_sh_en = '0;
            mac_en  = '0;
            i_inc   = 1'b0;
            k_inc   = 1'b0;
            k_clr   = 1'b0;
            j_inc   = 1'b0;
        end
    end

    assign busy = (state != S_IDLE) && (state != S_DONE);
    assign done = (state == S_DONE);

endmodule
